// File: rtl/emmc_resp_rx.sv
// eMMC CMD-line response receiver: Ncr wait, 48/136-bit framing,
// CRC7 check and field split for the command controller.
module emmc_resp_rx #(
  parameter int NCR_MAX    = 64,
  parameter int RESP_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en_i,
  input  logic                  cmd_i,
  input  logic                  start_i,
  input  logic                  long_i,
  input  logic                  crc_chk_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [5:0]            idx_o,
  output logic [RESP_WIDTH-1:0] resp_o,
  output logic                  crc_err_o,
  output logic                  frame_err_o,
  output logic                  timeout_o
);

  localparam int CNT_W = $clog2(NCR_MAX + 1);
  localparam logic [CNT_W-1:0] NCR_CAP  = CNT_W'(NCR_MAX);
  localparam logic [CNT_W-1:0] NCR_LAST = CNT_W'(NCR_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RECV,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            bit_q, bit_d;
  logic [CNT_W-1:0]      ncr_q, ncr_d;
  logic                  long_q, long_d;
  logic                  chk_q, chk_d;
  logic [6:0]            crc_q, crc_d;
  logic [6:0]            crx_q, crx_d;
  logic [5:0]            idx_q, idx_d;
  logic [RESP_WIDTH-1:0] resp_q, resp_d;
  logic                  cerr_q, cerr_d;
  logic                  ferr_q, ferr_d;
  logic                  tout_q, tout_d;
  logic [7:0]            last_bit;
  logic                  arm;

  function automatic logic [6:0] crc7_step(input logic [6:0] c,
                                           input logic d);
    logic fb;
    fb = c[6] ^ d;
    return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  assign last_bit = long_q ? 8'd135 : 8'd47;
  assign arm      = (state_q == S_IDLE) & start_i & ~abort_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      ncr_q   <= '0;
      long_q  <= 1'b0;
      chk_q   <= 1'b0;
      crc_q   <= '0;
      crx_q   <= '0;
      idx_q   <= '0;
      resp_q  <= '0;
      cerr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      ncr_q   <= ncr_d;
      long_q  <= long_d;
      chk_q   <= chk_d;
      crc_q   <= crc_d;
      crx_q   <= crx_d;
      idx_q   <= idx_d;
      resp_q  <= resp_d;
      cerr_q  <= cerr_d;
      ferr_q  <= ferr_d;
      tout_q  <= tout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (start_i) state_d = S_WAIT;
        S_WAIT: begin
          if (clk_en_i) begin
            if (!cmd_i)                 state_d = S_RECV;
            else if (ncr_q == NCR_LAST) state_d = S_DONE;
          end
        end
        S_RECV: begin
          if (clk_en_i && bit_q == last_bit) state_d = S_DONE;
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o = (state_q == S_WAIT) | (state_q == S_RECV);
    done_o = (state_q == S_DONE);
  end

  always_comb begin
    bit_d  = bit_q;
    ncr_d  = ncr_q;
    long_d = long_q;
    chk_d  = chk_q;
    crc_d  = crc_q;
    crx_d  = crx_q;
    idx_d  = idx_q;
    resp_d = resp_q;
    cerr_d = cerr_q;
    ferr_d = ferr_q;
    tout_d = tout_q;
    if (arm) begin
      long_d = long_i;
      // R2 frames are always CRC-checked
      chk_d  = crc_chk_i | long_i;
      bit_d  = '0;
      ncr_d  = '0;
      crc_d  = '0;
      crx_d  = '0;
      idx_d  = '0;
      resp_d = '0;
      cerr_d = 1'b0;
      ferr_d = 1'b0;
      tout_d = 1'b0;
    end else if (!abort_i && clk_en_i && state_q == S_WAIT) begin
      if (!cmd_i) begin
        bit_d = 8'd1;
      end else begin
        if (ncr_q != NCR_CAP) ncr_d = ncr_q + 1'b1;
        if (ncr_q == NCR_LAST) tout_d = 1'b1;
      end
    end else if (!abort_i && clk_en_i && state_q == S_RECV) begin
      bit_d = bit_q + 8'd1;
      if (bit_q == 8'd1 && cmd_i) ferr_d = 1'b1;
      if (!long_q && bit_q >= 8'd2 && bit_q <= 8'd7)
        idx_d = {idx_q[4:0], cmd_i};
      if (bit_q >= 8'd8 && bit_q <= (long_q ? 8'd134 : 8'd39))
        resp_d = {resp_q[RESP_WIDTH-2:0], cmd_i};
      // start bit is 0 and leaves a zero CRC unchanged
      if (long_q ? (bit_q >= 8'd8 && bit_q <= 8'd127) : (bit_q <= 8'd39))
        crc_d = crc7_step(crc_q, cmd_i);
      if (long_q ? (bit_q >= 8'd128 && bit_q <= 8'd134)
                 : (bit_q >= 8'd40 && bit_q <= 8'd46))
        crx_d = {crx_q[5:0], cmd_i};
      if (bit_q == last_bit) begin
        if (!cmd_i) ferr_d = 1'b1;
        cerr_d = chk_q & (crc_q != crx_q);
        if (long_q) begin
          idx_d  = 6'h3F;
          resp_d = {resp_q[RESP_WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  assign idx_o       = idx_q;
  assign resp_o      = resp_q;
  assign crc_err_o   = cerr_q;
  assign frame_err_o = ferr_q;
  assign timeout_o   = tout_q;

endmodule
